// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction decode stage: opcodes, control-bundle
// bit positions, FSM state encoding and immediate-extension helpers.
package ctrl_pkg;

    localparam int CTRL_W = 22;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LSL  = 5'b01010;
    localparam logic [4:0] OP_LSR  = 5'b01011;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;

    localparam int IS_ST        = 0;
    localparam int IS_LD        = 1;
    localparam int IS_BEQ       = 2;
    localparam int IS_BGT       = 3;
    localparam int IS_RET       = 4;
    localparam int IS_IMMEDIATE = 5;
    localparam int IS_WB        = 6;
    localparam int IS_UBRANCH   = 7;
    localparam int IS_CALL      = 8;
    localparam int IS_ADD       = 9;
    localparam int IS_SUB       = 10;
    localparam int IS_CMP       = 11;
    localparam int IS_MUL       = 12;
    localparam int IS_DIV       = 13;
    localparam int IS_MOD       = 14;
    localparam int IS_LSL       = 15;
    localparam int IS_LSR       = 16;
    localparam int IS_ASR       = 17;
    localparam int IS_OR        = 18;
    localparam int IS_AND       = 19;
    localparam int IS_NOT       = 20;
    localparam int IS_MOV       = 21;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_HOLD  = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    // Modifier 01 zero-extends, 10 places imm16 in the upper half, 00/11 sign-extend.
    function automatic logic [31:0] ext_imm(input logic [1:0] modifier, input logic [15:0] imm);
        logic [31:0] res;
        case (modifier)
            2'b01:   res = {16'h0000, imm};
            2'b10:   res = {imm, 16'h0000};
            default: res = {{16{imm[15]}}, imm};
        endcase
        return res;
    endfunction

    function automatic logic op_is_illegal(input logic [4:0] opcode);
        return (opcode > OP_RET);
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational instruction decoder: 32-bit instruction to control
// bundle, register indices and extended immediate.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int RA_REG = 15
) (
    input  logic [31:0]       instr_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [3:0]        rd_o,
    output logic [3:0]        rs1_o,
    output logic [3:0]        rs2_o,
    output logic [31:0]       imm_ext_o
);

    localparam logic [3:0] RA_IDX = 4'(RA_REG);

    logic wb_s;
    logic imm_sel_s;
    logic br_s;

    // Opcode decode; nop and unused opcodes fall through to an all-zero bundle.
    always_comb begin
        ctrl_o    = {CTRL_W{1'b0}};
        wb_s      = 1'b0;
        imm_sel_s = 1'b0;
        br_s      = 1'b0;
        rd_o      = instr_i[25:22];
        rs1_o     = instr_i[21:18];
        rs2_o     = instr_i[17:14];
        case (instr_i[31:27])
            OP_ADD:  begin ctrl_o[IS_ADD] = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_SUB:  begin ctrl_o[IS_SUB] = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_MUL:  begin ctrl_o[IS_MUL] = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_DIV:  begin ctrl_o[IS_DIV] = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_MOD:  begin ctrl_o[IS_MOD] = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_CMP:  begin ctrl_o[IS_CMP] = 1'b1; imm_sel_s = 1'b1; end
            OP_AND:  begin ctrl_o[IS_AND] = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_OR:   begin ctrl_o[IS_OR]  = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_NOT:  begin ctrl_o[IS_NOT] = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_MOV:  begin ctrl_o[IS_MOV] = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_LSL:  begin ctrl_o[IS_LSL] = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_LSR:  begin ctrl_o[IS_LSR] = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_ASR:  begin ctrl_o[IS_ASR] = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_LD:   begin ctrl_o[IS_LD]  = 1'b1; wb_s = 1'b1; imm_sel_s = 1'b1; end
            OP_ST: begin
                ctrl_o[IS_ST] = 1'b1;
                imm_sel_s     = 1'b1;
                rs2_o         = instr_i[25:22];
            end
            OP_BEQ:  begin ctrl_o[IS_BEQ] = 1'b1; br_s = 1'b1; end
            OP_BGT:  begin ctrl_o[IS_BGT] = 1'b1; br_s = 1'b1; end
            OP_B:    begin ctrl_o[IS_UBRANCH] = 1'b1; br_s = 1'b1; end
            OP_CALL: begin
                ctrl_o[IS_CALL]    = 1'b1;
                ctrl_o[IS_UBRANCH] = 1'b1;
                wb_s               = 1'b1;
                br_s               = 1'b1;
                rd_o               = RA_IDX;
            end
            OP_RET: begin
                ctrl_o[IS_RET]     = 1'b1;
                ctrl_o[IS_UBRANCH] = 1'b1;
                rs1_o              = RA_IDX;
            end
            default: ctrl_o = {CTRL_W{1'b0}};
        endcase
        ctrl_o[IS_WB]        = wb_s;
        ctrl_o[IS_IMMEDIATE] = imm_sel_s & instr_i[26];
        // Branch offsets take the whole 27-bit field below the opcode.
        imm_ext_o = br_s ? {{5{instr_i[26]}}, instr_i[26:0]}
                         : ext_imm(instr_i[17:16], instr_i[15:0]);
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage with valid/ready on both sides and a cooldown after
// mul/div/mod. Optional trap on illegal opcodes: ILLEGAL_OPCODE_TRAP_EN.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int MULTI_LAT = 4,
    parameter int RA_REG    = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         instr,
    input  logic                flush,
    output logic                ctrl_valid,
    input  logic                ctrl_ready,
    output logic [CTRL_W-1:0]   control_signals,
    output logic [3:0]          rd,
    output logic [3:0]          rs1,
    output logic [3:0]          rs2,
    output logic [31:0]         imm_ext,
    output logic                illegal
);

    localparam logic [3:0] HOLD_CNT   = 4'(MULTI_LAT - 1);
    localparam logic       MULTI_HOLD = (MULTI_LAT > 1) ? 1'b1 : 1'b0;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [3:0]          rd_q, rd_d;
    logic [3:0]          rs1_q, rs1_d;
    logic [3:0]          rs2_q, rs2_d;
    logic [31:0]         imm_q, imm_d;
    logic                illegal_q, illegal_d;

    logic [CTRL_W-1:0]   dec_ctrl_s;
    logic [3:0]          dec_rd_s;
    logic [3:0]          dec_rs1_s;
    logic [3:0]          dec_rs2_s;
    logic [31:0]         dec_imm_s;
    logic                held_multi_s;
    logic                ready_base_s;
    logic                accept_s;
    logic                trap_s;

    ctrl_decoder #(
        .RA_REG(RA_REG)
    ) u_dec (
        .instr_i   (instr),
        .ctrl_o    (dec_ctrl_s),
        .rd_o      (dec_rd_s),
        .rs1_o     (dec_rs1_s),
        .rs2_o     (dec_rs2_s),
        .imm_ext_o (dec_imm_s)
    );

`ifdef ILLEGAL_OPCODE_TRAP_EN
    assign trap_s = op_is_illegal(instr[31:27]);
`else
    assign trap_s = 1'b0;
`endif

    assign held_multi_s = ctrl_q[IS_MUL] | ctrl_q[IS_DIV] | ctrl_q[IS_MOD];

    // Input-side readiness per state; a held multi-cycle op blocks back-to-back issue.
    always_comb begin
        case (state_q)
            ST_EMPTY: ready_base_s = 1'b1;
            ST_FULL:  ready_base_s = ctrl_ready & ~held_multi_s;
            default:  ready_base_s = 1'b0;
        endcase
    end

    // Flush drops readiness so an instruction offered alongside it is never taken.
    assign instr_ready = ready_base_s & ~flush & ~rst;
    assign accept_s    = instr_valid & instr_ready;

    // Next-state and output-register update; flush dominates everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d   = ST_EMPTY;
            cnt_d     = 4'd0;
            illegal_d = 1'b0;
        end else if (accept_s) begin
            if (trap_s) begin
                state_d   = ST_HALT;
                illegal_d = 1'b1;
                ctrl_d    = {CTRL_W{1'b0}};
                rd_d      = 4'd0;
                rs1_d     = 4'd0;
                rs2_d     = 4'd0;
                imm_d     = 32'd0;
            end else begin
                state_d   = ST_FULL;
                ctrl_d    = dec_ctrl_s;
                rd_d      = dec_rd_s;
                rs1_d     = dec_rs1_s;
                rs2_d     = dec_rs2_s;
                imm_d     = dec_imm_s;
            end
        end else begin
            case (state_q)
                ST_EMPTY: state_d = ST_EMPTY;
                ST_FULL: begin
                    if (ctrl_ready) begin
                        if (held_multi_s && MULTI_HOLD) begin
                            state_d = ST_HOLD;
                            cnt_d   = HOLD_CNT;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_EMPTY;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Stage registers; asynchronous reset clears every output immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            cnt_q     <= 4'd0;
            ctrl_q    <= {CTRL_W{1'b0}};
            rd_q      <= 4'd0;
            rs1_q     <= 4'd0;
            rs2_q     <= 4'd0;
            imm_q     <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign ctrl_valid      = (state_q == ST_FULL);
    assign control_signals = ctrl_q;
    assign rd              = rd_q;
    assign rs1             = rs1_q;
    assign rs2             = rs2_q;
    assign imm_ext         = imm_q;
    assign illegal         = illegal_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: directed instructions with
// hand-decoded expected bundles, checked by an independent output monitor.
module tb_ctrl_decode_stage;

    typedef struct packed {
        logic [21:0] ctrl;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic        flush = 1'b0;
    logic        ctrl_valid;
    logic        ctrl_ready = 1'b0;
    logic [21:0] control_signals;
    logic [3:0]  rd, rs1, rs2;
    logic [31:0] imm_ext;
    logic        illegal;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ctrl_decode_stage #(.MULTI_LAT(4), .RA_REG(15)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .flush(flush), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .control_signals(control_signals), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm_ext(imm_ext), .illegal(illegal)
    );

    function automatic exp_t mk(input logic [21:0] c, input logic [3:0] d, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [31:0] im);
        exp_t e;
        e.ctrl = c; e.rd = d; e.rs1 = s1; e.rs2 = s2; e.imm = im;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call right after a posedge: offers one instruction and records its expected bundle.
    task automatic send(input logic [31:0] w, input bit push, input exp_t e);
        int n;
        instr = w;
        instr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: instr %h not accepted within 50 cycles", w);
        end else if (push) begin
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 32'd0;
    endtask

    // Monitor: compare the presented bundle with the scoreboard head; pop on handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && ctrl_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: bundle ctrl %h with nothing expected", control_signals);
            end else begin
                e = sb_q[0];
                chk(ctrl_ready ? "out_ctrl" : "hold_ctrl", 32'(control_signals), 32'(e.ctrl));
                chk(ctrl_ready ? "out_rd"   : "hold_rd",   32'(rd),   32'(e.rd));
                chk(ctrl_ready ? "out_rs1"  : "hold_rs1",  32'(rs1),  32'(e.rs1));
                chk(ctrl_ready ? "out_rs2"  : "hold_rs2",  32'(rs2),  32'(e.rs2));
                chk(ctrl_ready ? "out_imm"  : "hold_imm",  imm_ext,   e.imm);
                chk("out_illegal", 32'(illegal), 32'd0);
                if (ctrl_ready) begin
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t none;
        none = mk(22'h0, 4'd0, 4'd0, 4'd0, 32'h0);

        // Reset state
        @(negedge clk);
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_ctrl_valid",  32'(ctrl_valid),  32'd0);
        chk("rst_ctrl",        32'(control_signals), 32'd0);
        chk("rst_illegal",     32'(illegal), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(instr_ready), 32'd1);
        step();
        ctrl_ready = 1'b1;

        // add r1,r2,r3 and its one-cycle latency
        send(32'h0048C000, 1'b1, mk(22'h000240, 4'd1, 4'd2, 4'd3, 32'hFFFFC000));
        @(negedge clk);
        chk("latency_valid", 32'(ctrl_valid), 32'd1);
        step();

        // Immediate modifiers, store, branches, call/ret back-to-back
        send(32'h0448FFFC, 1'b1, mk(22'h000260, 4'd1, 4'd2, 4'd3, 32'hFFFFFFFC));
        send(32'h0449FFFC, 1'b1, mk(22'h000260, 4'd1, 4'd2, 4'd7, 32'h0000FFFC));
        send(32'h044AFFFC, 1'b1, mk(22'h000260, 4'd1, 4'd2, 4'hB, 32'hFFFC0000));
        send(32'h7CC80008, 1'b1, mk(22'h000021, 4'd3, 4'd2, 4'd3, 32'h00000008));
        send(32'h80000100, 1'b1, mk(22'h000004, 4'd0, 4'd0, 4'd0, 32'h00000100));
        send(32'h9C000010, 1'b1, mk(22'h0001C0, 4'd15, 4'd0, 4'd0, 32'hFC000010));
        send(32'hA0000000, 1'b1, mk(22'h000090, 4'd0, 4'd15, 4'd0, 32'h00000000));

        // mul and its cooldown
        send(32'h11158000, 1'b1, mk(22'h001040, 4'd4, 4'd5, 4'd6, 32'h00008000));
        @(negedge clk);
        chk("mul_valid",         32'(ctrl_valid),  32'd1);
        chk("mul_ready_blocked", 32'(instr_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ctrl_valid),  32'd0);
            chk("hold_ready", 32'(instr_ready), 32'd0);
        end
        @(negedge clk);
        chk("cooldown_done", 32'(instr_ready), 32'd1);
        step();

        // cmp stream against a toggling consumer
        fork
            begin
                send(32'h28048000, 1'b1, mk(22'h000800, 4'd0, 4'd1, 4'd2, 32'hFFFF8000));
                send(32'h280D0000, 1'b1, mk(22'h000800, 4'd0, 4'd3, 4'd4, 32'h00000000));
                send(32'h28944000, 1'b1, mk(22'h000800, 4'd2, 4'd5, 4'd1, 32'h00004000));
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    ctrl_ready = (i % 2 == 0);
                    step();
                end
                ctrl_ready = 1'b1;
            end
        join
        repeat (3) step();
        chk("stream_drained", 32'(sb_q.size()), 32'd0);

        // Flush during mul cooldown, with a competing instruction offered
        send(32'h11158000, 1'b1, mk(22'h001040, 4'd4, 4'd5, 4'd6, 32'h00008000));
        step();
        flush = 1'b1;
        instr = 32'h0048C000;
        instr_valid = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", 32'(instr_ready), 32'd0);
        step();
        flush = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("flush_empty_ready", 32'(instr_ready), 32'd1);
        chk("flush_no_valid",    32'(ctrl_valid),  32'd0);
        step();

        // Illegal opcode 10101
`ifdef ILLEGAL_OPCODE_TRAP_EN
        send(32'hA8000000, 1'b0, none);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("halt_illegal", 32'(illegal),     32'd1);
            chk("halt_ready",   32'(instr_ready), 32'd0);
            chk("halt_valid",   32'(ctrl_valid),  32'd0);
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("halt_exit_illegal", 32'(illegal),     32'd0);
        chk("halt_exit_ready",   32'(instr_ready), 32'd1);
        step();
`else
        send(32'hA8000000, 1'b1, none);
        @(negedge clk);
        chk("illegal_as_nop_valid", 32'(ctrl_valid), 32'd1);
        chk("illegal_tied_low",     32'(illegal),    32'd0);
        step();
`endif

        // Asynchronous reset while a bundle is stalled
        ctrl_ready = 1'b0;
        send(32'h0048C000, 1'b1, mk(22'h000240, 4'd1, 4'd2, 4'd3, 32'hFFFFC000));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ctrl_valid),      32'd0);
        chk("arst_ctrl",  32'(control_signals), 32'd0);
        chk("arst_rd",    32'(rd),              32'd0);
        chk("arst_imm",   imm_ext,              32'd0);
        chk("arst_ready", 32'(instr_ready),     32'd0);
        sb_q.delete();
        step();
        rst = 1'b0;
        ctrl_ready = 1'b1;
        @(negedge clk);
        chk("arst_release_ready", 32'(instr_ready), 32'd1);

        repeat (3) step();
        chk("sb_empty_end", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Instruction decode stage feeding the ALU/execute stage. It generates the 22-bit control_signals bundle, register indices and extended immediate for each 32-bit instruction.
- Single registered pipeline stage with valid/ready handshakes on both sides.
- Enforces a cooldown after multi-cycle ALU ops (mul/div/mod) so the ALU is not re-issued before its result settles.

Parameters:
- MULTI_LAT, 4, ALU cycles needed by mul/div/mod; legal range 1..15.
- RA_REG, 15, register index used as rs1 for ret.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- instr_valid  input  1  fetch presents instruction
- instr_ready  output  1  stage accepts instruction this cycle
- instr  input  32  [31:27] opcode, [26] I, [25:22] rd, [21:18] rs1, [17:14] rs2, [17:16] imm modifier, [15:0] imm
- flush  input  1  synchronous pipeline flush (branch taken)
- ctrl_valid  output  1  decoded bundle valid
- ctrl_ready  input  1  execute stage consumes bundle
- control_signals  output  22  bit 0 isSt, 1 isLd, 2 isBeq, 3 isBgt, 4 isRet, 5 isImmediate, 6 isWb, 7 isUBranch, 8 isCall, 9 isAdd, 10 isSub, 11 isCmp, 12 isMul, 13 isDiv, 14 isMod, 15 isLsl, 16 isLsr, 17 isAsr, 18 isOr, 19 isAnd, 20 isNot, 21 isMov
- rd, rs1, rs2  output  4 each  register indices
- imm_ext  output  32  extended immediate or branch offset
- illegal  output  1  illegal opcode held (feature only, else tied 0)

Behaviour:
- Reset: state EMPTY, all outputs 0, instr_ready 0 during reset, 1 in the first cycle after release.
- Opcode map:
  - add 00000, sub 00001, mul 00010, div 00011, mod 00100, cmp 00101, and 00110, or 00111, not 01000, mov 01001, lsl 01010, lsr 01011, asr 01100, nop 01101
  - ld 01110, st 01111, beq 10000, bgt 10001, b 10010, call 10011, ret 10100
  - 10101..11111 illegal
- isWb: set for the ALU ops except cmp, for ld, and for call. isImmediate = instr[26] for ALU/ld/st. isUBranch: b, call, ret.
- Register indices:
  - st: rs2 = instr[25:22].
  - ret: rs1 = RA_REG.
  - call: rd = RA_REG.
- imm_ext:
  - modifier 00: sign-extend imm16.
  - modifier 01: zero-extend imm16.
  - modifier 10: {imm16, 16'h0}.
  - modifier 11: sign-extend imm16.
  - Branches (beq, bgt, b, call): sign-extend instr[26:0].
- Latency: 1 cycle from accept to ctrl_valid. Outputs are registered and stay stable while ctrl_valid=1 and ctrl_ready=0.
- States:
  - EMPTY: instr_ready=1. Accept → FULL.
  - FULL: ctrl_valid=1. instr_ready = ctrl_ready AND held op not mul/div/mod.
    - On handshake with multi op and MULTI_LAT>1 → HOLD, cnt = MULTI_LAT-1.
    - Else, if a new instr is accepted the same cycle → FULL (back-to-back, full throughput).
    - Else → EMPTY.
  - HOLD: ctrl_valid=0, instr_ready=0, cnt decrements; cnt==1 → EMPTY.
    - Net effect: output handshake at cycle t ⇒ instr_ready high again at t+MULTI_LAT.
  - HALT (feature only): ctrl_valid=0, instr_ready=0, illegal=1.
- flush: highest priority; next state EMPTY, ctrl_valid=0, same-cycle instr_valid ignored, cnt cleared, HALT exited.
- flush and rst mid-HOLD both abort the cooldown.
- Asynchronous rst in any state forces all outputs 0 immediately.

Optional Feature:
- Macro ILLEGAL_OPCODE_TRAP_EN.
- Defined:
  - An illegal opcode is accepted, then → HALT with illegal=1 and control_signals=0.
  - Leaves HALT only on flush or rst.
- Undefined:
  - Illegal opcodes decode as nop: control_signals=0, ctrl_valid=1, normal flow.
  - illegal tied 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams
  - control-bit index constants (IS_ST=0 … IS_MOV=21)
  - CTRL_W=22
  - state encoding
- Sub-module ctrl_decoder: purely combinational instr → bundle/indices/imm. The stage wrapper holds registers, FSM and cooldown counter.

Test Plan:
- instr=0x0048C000 (add r1,r2,r3), ctrl_ready=1 → next cycle ctrl_valid=1, control_signals=0x000240, rd=1, rs1=2, rs2=3.
- instr=0x0448FFFC (addi r1,r2,-4) → control_signals=0x000260, imm_ext=0xFFFFFFFC. Same instruction with modifier 01 → imm_ext=0x0000FFFC.
- instr=0x11158000 (mul r4,r5,r6), MULTI_LAT=4, ctrl_ready=1 → control_signals=0x001040. After handshake, ctrl_valid=0 and instr_ready=0 for 3 cycles, then instr_ready=1.
- Back-to-back cmp (opcode 00101) stream with ctrl_ready toggling 1,0,1 → control_signals=0x000800, one bundle per ready cycle, values stable while stalled, no drops or duplicates.
- instr=0xA0000000 (ret) → control_signals=0x000090, rs1=15. Assert flush during a mul HOLD → EMPTY next cycle, instr_ready=1.
- instr=0xA8000000 (opcode 10101) → with ILLEGAL_OPCODE_TRAP_EN: illegal=1, instr_ready=0 until flush. Without the macro: control_signals=0, ctrl_valid=1.
